// File: rtl/mult16_rr_scheduler.sv
// Round-robin front end sharing one 16x16 unsigned array multiplier between two requesters.
// Latency: SETTLE_CYCLES edges from request handshake to rsp_valid; backpressure: response held until rsp_ready, no new grants until drained.
// Backpressure: reqN_ready only in IDLE, so a stalled response blocks both requesters.
module mult16_rr_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_product,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] mul_p;
    logic        grant_vld;
    logic        grant_id;

    // Tie goes to the requester not served last; readys are held low while rst is high.
    always_comb begin
        grant_vld = (state == IDLE) && !rst && (req0_valid || req1_valid);
        grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;
    assign busy       = (state != IDLE);

    sixteen_bit_multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            op_a        <= 16'd0;
            op_b        <= 16'd0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a       <= grant_id ? req1_a : req0_a;
                        op_b       <= grant_id ? req1_b : req0_b;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= SETTLE_LD;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Exiting at <=1 keeps an illegal zero setting from wrapping the counter.
                    if (cnt <= 4'd1) begin
                        cnt         <= 4'd0;
                        rsp_product <= mul_p;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// Combinational 16x16 unsigned shift-and-add array multiplier (SixTeenBitMultiplier).
// Latency: purely combinational, needs settle time before capture.
// Backpressure: none.
module sixteen_bit_multiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] acc;

    // Each row adds a shifted partial product; the final carry lands in bit 31.
    always_comb begin
        acc = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                acc = acc + ({16'd0, a} << i);
            end
        end
    end

    assign p = acc;

endmodule
